rvp_run_ctrl: RTL and testbench

Run controller for `riscv_pipeline`. It sequences one program run:
- holds the core in reset, releases it at a latched start PC, and monitors `pc_out` for a halt address or a cycle budget;
- drains the pipeline, pulses `dump` to the core, then parks the core in reset and reports completion with cycle and retire counts.

It sits between the system/bench level and the pipeline and replaces hand-timed reset, loop and dump sequencing.

---
 rtl/rvp_ctrl_pkg.sv | 26 ++
 rtl/rvp_sat_cnt.sv | 24 ++
 rtl/rvp_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_rvp_run_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvp_ctrl_pkg.sv
// Shared state encoding and constants for the riscv_pipeline run controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package rvp_ctrl_pkg;

  localparam int         RVP_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_DRAIN,
    ST_DUMP,
    ST_DONE
  } rvp_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int ph_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/rvp_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible one cycle after inc; clear has priority over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module rvp_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rvp_run_ctrl.sv
// Sequences one riscv_pipeline run: hold reset, run to halt PC or budget, drain, dump, park.
// Latency: all outputs registered; HOLD_CYCLES of reset after start, DRAIN_CYCLES+1 to dump.
// Backpressure: none; start is only honoured in IDLE/DONE, abort wins over everything else.
module rvp_run_ctrl
  import rvp_ctrl_pkg::*;
#(
  parameter int XLEN         = RVP_XLEN,
  parameter int CNT_W        = 32,
  parameter int HOLD_CYCLES  = 20,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_CYCLES   = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [XLEN-1:0]  pc_start,
  input  logic [XLEN-1:0]  halt_pc,
  input  logic [XLEN-1:0]  pc_out,
  input  logic             wb_e,
  input  logic [4:0]       wb_a,
  output logic             core_reset,
  output logic [XLEN-1:0]  pc_init,
  output logic             dump,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] run_cycles,
  output logic [CNT_W-1:0] retired
);

  localparam int PH_MAX = (HOLD_CYCLES - 1 > DRAIN_CYCLES) ? HOLD_CYCLES - 1 : DRAIN_CYCLES;
  localparam int PH_W   = ph_width(PH_MAX);

  localparam logic [PH_W-1:0]  HOLD_LOAD  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LOAD = PH_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MAX_CYCLES - 1);

  rvp_state_e      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [XLEN-1:0] halt_q;
  logic            timeout_d;
  logic            start_ok;
  logic            halt_hit;
  logic            budget_hit;
  logic            run_inc;
  logic            ret_inc;

  // Abort in DONE beats a simultaneous restart, so the counters are not cleared then.
  assign start_ok   = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !abort));
  assign halt_hit   = pc_out >= halt_q;
  assign budget_hit = run_cycles == RUN_LAST;

  assign run_inc = (state_q == ST_RUN) && !abort;
  assign ret_inc = ((state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_DUMP)) &&
                   !abort && wb_e && (wb_a != REG_ZERO);

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    timeout_d = timeout;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_HOLD;
            ph_d      = HOLD_LOAD;
            timeout_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (ph_q == '0) state_d = ST_RUN;
          else            ph_d    = ph_q - 1'b1;
        end
        ST_RUN: begin
          // Halt is checked first so a coincident budget expiry is not reported.
          if (halt_hit) begin
            state_d = ST_DRAIN;
            ph_d    = DRAIN_LOAD;
          end else if (budget_hit) begin
            state_d   = ST_DRAIN;
            ph_d      = DRAIN_LOAD;
            timeout_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ph_q == '0) state_d = ST_DUMP;
          else            ph_d    = ph_q - 1'b1;
        end
        ST_DUMP: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      halt_q     <= '0;
      pc_init    <= '0;
      timeout    <= 1'b0;
      core_reset <= 1'b1;
      dump       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      timeout    <= timeout_d;
      core_reset <= (state_d == ST_IDLE) || (state_d == ST_HOLD) || (state_d == ST_DONE);
      dump       <= state_d == ST_DUMP;
      busy       <= !((state_d == ST_IDLE) || (state_d == ST_DONE));
      done       <= state_d == ST_DONE;
      if (start_ok) begin
        pc_init <= pc_start;
        halt_q  <= halt_pc;
      end
    end
  end

  rvp_sat_cnt #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start_ok),
    .inc   (run_inc),
    .cnt   (run_cycles)
  );

  rvp_sat_cnt #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start_ok),
    .inc   (ret_inc),
    .cnt   (retired)
  );

endmodule

// File: tb/tb_rvp_run_ctrl.sv
// Directed bench for rvp_run_ctrl: hold timing, halt/timeout runs, retire count, abort, reset.
module tb_rvp_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] pc_start;
  logic [31:0] halt_pc;
  logic [31:0] pc_out;
  logic        wb_e;
  logic [4:0]  wb_a;
  logic        core_reset;
  logic [31:0] pc_init;
  logic        dump;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;
  logic [31:0] retired;

  int n_tests;
  int n_fail;
  int cyc;
  int dump_cnt;
  int dump_at;
  int det_at;
  bit pc_step;
  bit cr_ok;
  int n;

  rvp_run_ctrl #(
    .XLEN(32), .CNT_W(32), .HOLD_CYCLES(20), .DRAIN_CYCLES(4), .MAX_CYCLES(200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pc_start   (pc_start),
    .halt_pc    (halt_pc),
    .pc_out     (pc_out),
    .wb_e       (wb_e),
    .wb_a       (wb_a),
    .core_reset (core_reset),
    .pc_init    (pc_init),
    .dump       (dump),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .run_cycles (run_cycles),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: observe on the falling edge, then advance the pipeline PC model.
  // The modelled core steps its PC by 4 on every cycle it is out of reset.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (dump) begin
      dump_cnt++;
      if (dump_at == 0) dump_at = cyc;
    end
    if (pc_step && busy && !core_reset) begin
      pc_out = pc_out + 32'd4;
      if (det_at == 0 && pc_out >= halt_pc) det_at = cyc + 1;
    end
  endtask

  task automatic begin_run(input logic [31:0] ps, input logic [31:0] hp,
                           input logic [31:0] pc0, input bit stepping);
    pc_start = ps;
    halt_pc  = hp;
    pc_out   = pc0;
    pc_step  = stepping;
    dump_cnt = 0;
    dump_at  = 0;
    det_at   = 0;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    dump_cnt = 0; dump_at = 0; det_at = 0; pc_step = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pc_start = '0; halt_pc = '0; pc_out = '0; wb_e = 1'b0; wb_a = '0;

    // Reset values.
    repeat (3) step();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_dump", dump, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pc_init", pc_init, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_retired", retired, 0);
    reset = 1'b1;
    repeat (2) step();

    // Hold timing, then a normal halt run with retire traffic and an ignored mid-run start.
    begin_run(32'h40, 32'd52, 32'd0, 1'b1);
    chk("hold_busy", busy, 1);
    cr_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!core_reset) cr_ok = 1'b0;
      step();
    end
    chk("hold_core_reset_20", cr_ok, 1);
    chk("hold_release", core_reset, 0);
    chk("hold_pc_init", pc_init, 32'h40);
    for (int j = 0; j < 20; j++) begin
      wb_e = 1'b0; wb_a = 5'd0; start = 1'b0;
      case (j)
        1, 3, 5, 7, 9: begin wb_e = 1'b1; wb_a = 5'((j + 1) / 2); end
        13:            begin wb_e = 1'b1; wb_a = 5'd6; end
        15:            begin wb_e = 1'b1; wb_a = 5'd7; end
        2, 8, 14:      begin wb_e = 1'b1; wb_a = 5'd0; end
        6:             start = 1'b1;
        default: ;
      endcase
      step();
      if (j == 6) chk("mid_start_ignored", core_reset, 0);
    end
    wb_e = 1'b0; wb_a = 5'd0; start = 1'b0;
    chk("norm_done", done, 1);
    chk("norm_busy", busy, 0);
    chk("norm_core_reset", core_reset, 1);
    chk("norm_timeout", timeout, 0);
    chk("norm_run_cycles", run_cycles, 13);
    chk("norm_retired", retired, 7);
    chk("norm_dump_count", dump_cnt, 1);
    chk("norm_dump_latency", dump_at - det_at, 5);
    chk("norm_pc_init_hold", pc_init, 32'h40);

    // Restart from DONE into a budget timeout (PC stuck below the halt address).
    begin_run(32'h0, 32'd150, 32'd12, 1'b0);
    chk("restart_busy", busy, 1);
    chk("restart_done_clr", done, 0);
    chk("restart_run_clr", run_cycles, 0);
    chk("restart_ret_clr", retired, 0);
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    chk("tmo_done", done, 1);
    chk("tmo_timeout", timeout, 1);
    chk("tmo_run_cycles", run_cycles, 200);
    chk("tmo_dump_count", dump_cnt, 1);

    // Halt reached on the very cycle the budget expires: halt wins.
    begin_run(32'h0, 32'd800, 32'd0, 1'b1);
    chk("sim_timeout_clr", timeout, 0);
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    chk("sim_done", done, 1);
    chk("sim_timeout", timeout, 0);
    chk("sim_run_cycles", run_cycles, 200);
    chk("sim_dump_count", dump_cnt, 1);

    // Abort while draining: back to IDLE, counters held, no dump.
    begin_run(32'h0, 32'd8, 32'd0, 1'b1);
    n = 0;
    while (core_reset && n < 50) begin step(); n++; end
    chk("abort_run_entry", core_reset, 0);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_done", done, 0);
    chk("abort_run_hold", run_cycles, 2);
    repeat (10) step();
    chk("abort_no_dump", dump_cnt, 0);
    chk("abort_stays_idle", busy, 0);

    // Asynchronous reset in the middle of RUN.
    begin_run(32'h80, 32'd1000, 32'd0, 1'b1);
    n = 0;
    while (core_reset && n < 50) begin step(); n++; end
    chk("rrun_entry", core_reset, 0);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rrun_core_reset", core_reset, 1);
    chk("rrun_busy", busy, 0);
    chk("rrun_done", done, 0);
    chk("rrun_dump", dump, 0);
    chk("rrun_timeout", timeout, 0);
    chk("rrun_pc_init", pc_init, 0);
    chk("rrun_run_cycles", run_cycles, 0);
    chk("rrun_retired", retired, 0);
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("rrun_after_release_busy", busy, 0);
    chk("rrun_after_release_cr", core_reset, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
